// File: rtl/demux_4ch.sv
// Four-channel valid/ready demultiplexer: one registered buffer slot per channel,
// routed by in_sel, with a saturating delivered-word counter per channel.
module demux_4ch #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [1:0]          in_sel,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*WIDTH-1:0]  out_data,
  output logic [4*CNTW-1:0]   cnt
);

  localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

  logic [3:0]            full_q, full_d;
  logic [WIDTH-1:0]      data_q [4];
  logic [WIDTH-1:0]      data_d [4];
  logic [CNTW-1:0]       cnt_q  [4];
  logic [CNTW-1:0]       cnt_d  [4];
  logic [3:0]            out_hs;
  logic [3:0]            load;
  logic                  in_hs;

  // A full slot can still accept when it is being drained in the same cycle.
  assign in_ready = ~full_q[in_sel] | out_ready[in_sel];
  assign in_hs    = in_valid & in_ready;

  always_comb begin
    out_hs = '0;
    load   = '0;
    full_d = full_q;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      cnt_d[k]  = cnt_q[k];
      out_hs[k] = full_q[k] & out_ready[k];
      load[k]   = in_hs & (in_sel == 2'(k));
      full_d[k] = load[k] | (full_q[k] & ~out_hs[k]);
      if (load[k]) begin
        data_d[k] = in_data;
      end
      if (out_hs[k] && (cnt_q[k] != CntMax)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  always_comb begin
    out_valid = full_q;
    out_data  = '0;
    cnt       = '0;
    for (int k = 0; k < 4; k++) begin
      out_data[k*WIDTH +: WIDTH] = data_q[k];
      cnt[k*CNTW +: CNTW]        = cnt_q[k];
    end
  end

endmodule

// File: doc/demux_4ch.md
DEMUX_4CH -- requirements
Module: demux_4ch

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving the payload data width in bits.
REQ-002 SHALL provide parameter CNTW, default 8, giving the width of each per-channel delivered-word counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream word is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-008 SHALL have port in_sel, input, 2 bits: destination channel 0..3, qualified by in_valid.
REQ-009 SHALL have port out_valid, output, 4 bits: bit k means channel k holds a word.
REQ-010 SHALL have port out_ready, input, 4 bits: bit k means the channel-k consumer accepts.
REQ-011 SHALL have port out_data, output, 4*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port cnt, output, 4*CNTW bits: channel k's delivered-word count occupies bits [k*CNTW +: CNTW].

Function
REQ-013 SHALL hold one registered buffer entry per channel (data plus full flag); out_valid[k] SHALL equal channel k's full flag.
REQ-014 SHALL drive in_ready combinationally as ~out_valid[in_sel] | out_ready[in_sel], independent of in_valid.
REQ-015 SHALL count an input handshake when in_valid & in_ready; it SHALL then load in_data into buffer in_sel and set out_valid[in_sel] on the next edge (latency 1 cycle).
REQ-016 SHALL count an output handshake on channel k when out_valid[k] & out_ready[k]; it SHALL clear out_valid[k] on the next edge unless the same cycle reloads channel k.
REQ-017 SHALL, on an output handshake and input handshake to the same channel in the same cycle, keep out_valid[k]=1 and replace out_data[k] with the new word, sustaining 1 word/cycle per channel.
REQ-018 SHALL never modify the buffers of channels other than in_sel, and SHALL keep out_data[k] stable while out_valid[k]=1 and out_ready[k]=0.
REQ-019 SHALL never overwrite or drop a word: while out_valid[in_sel]=1 and out_ready[in_sel]=0, in_ready=0 and the upstream word stalls.
REQ-020 SHALL allow output handshakes on any subset of the 4 channels in the same cycle, alongside at most one input handshake.
REQ-021 SHALL increment cnt[k] by 1 on each channel-k output handshake, saturating at 2^CNTW-1 (no wrap).
REQ-022 SHALL ignore in_sel and in_data when in_valid=0; out_data[k] is don't-care while out_valid[k]=0.

Reset
REQ-023 SHALL, on any rising edge with rst=1, clear out_valid to 4'b0000, all out_data to 0, and all cnt to 0, regardless of pending handshakes.
REQ-024 SHALL drive in_ready=1 during and immediately after reset, because all buffers are empty.
REQ-025 SHALL discard in-flight words on mid-operation reset, with no handshake counted in the reset cycle.

Verification
REQ-026 The bench SHALL cover this basic route: rst 2 cycles; then in_valid=1, in_sel=2, in_data=8'hA5 with out_ready=0 -> next cycle out_valid=4'b0100, out_data[2]=8'hA5, cnt all 0.
REQ-027 The bench SHALL cover this backpressure case: channel 1 full with out_ready[1]=0 and a new word for sel=1 -> in_ready=0 and out_data[1] unchanged; raising out_ready[1] -> in_ready=1 and the new word replaces the old one next cycle with out_valid[1] held at 1.
REQ-028 The bench SHALL cover this independence case: channel 0 stalled and full, then words sent to sel=3 -> in_ready=1 and channel 3 loads while channel 0 is untouched.
REQ-029 The bench SHALL cover this streaming case: out_ready=4'b1111 with 16 consecutive words cycling sel 0,1,2,3 -> in_ready=1 every cycle, each word appears 1 cycle later, and each cnt[k] ends at 4.
REQ-030 The bench SHALL cover counter saturation: CNTW=2 with 5 deliveries on channel 0 -> cnt[0] reads 3 and stays at 3.
REQ-031 The bench SHALL cover mid-operation reset: rst asserted while out_valid=4'b1011 and an input handshake is pending -> next cycle out_valid=0, all cnt=0, in_ready=1.
